mem_sync_rw: RTL

- Parametrised synchronous single-port word memory; successor to the 4-word combinational byte store.
- Adds registered read with 1-cycle latency, read-valid strobe, and a post-reset hardware clear sweep.
- Adds sticky error detection for read/write conflict and out-of-range address.
- Sits behind the processor/bus interface as general-purpose scratch storage.

---
 rtl/mem_pkg.sv | 25 ++
 rtl/mem_array_sp.sv | 39 +++
 rtl/mem_sync_rw.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the synchronous scratch memory (mem_sync_rw).
// Holds the FSM state type, the default geometry and the even-parity helper
// used when the design is built with MEM_PARITY_EN defined.
package mem_pkg;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_ADDR_W   = 8;
    localparam int DEF_DEPTH    = 256;

    // Widest word the parity helper covers; callers zero-extend narrower data.
    localparam int PARITY_MAX_W = 64;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    // Even-parity bit: makes the total count of ones, parity bit included, even.
    // Zero-extension does not change the result, so any DATA_W up to
    // PARITY_MAX_W can share this one function.
    function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/mem_array_sp.sv
// Single-port storage array for mem_sync_rw: one synchronous write port and a
// registered read port sharing a single address. The read register can be
// loaded with zero instead of array data for reads that fall outside the array.
module mem_array_sp #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic              wr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              rd,
    input  logic              rd_zero,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Synchronous write into the array.
    // NOTE: the array itself has no reset; the clear sweep zeroes it after reset,
    // which keeps the storage mappable onto plain RAM macros.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem[addr] <= wdata;
        end
    end

    // Registered read: data for a read sampled at edge N is held from edge N on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (rd) begin
            rdata <= rd_zero ? '0 : mem[addr];
        end
    end

endmodule

// File: rtl/mem_sync_rw.sv
// Synchronous single-port scratch memory with 1-cycle registered read,
// read-valid strobe, post-reset clear sweep and sticky error flags.
// Build option: define MEM_PARITY_EN to store an even-parity bit per word and
// flag parity mismatches on rd_perr; without it rd_perr is tied low.
module mem_sync_rw
    import mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ready,
    input  logic [ADDR_W-1:0] addr,
    input  logic              write_en,
    input  logic              read_en,
    input  logic [DATA_W-1:0] write_in,
    output logic [DATA_W-1:0] read_out,
    output logic              rd_valid,
    output logic              err_conflict,
    output logic              err_range,
    input  logic              err_clr,
    output logic              rd_perr
);

`ifdef MEM_PARITY_EN
    localparam int WORD_W = DATA_W + 1;
`else
    localparam int WORD_W = DATA_W;
`endif

    // One extra pointer bit so that DEPTH == 2**ADDR_W still has a reachable last index.
    localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_PTR = DEPTH_L - 1'b1;

    state_t            state;
    state_t            next_state;
    logic              sweep;
    logic [ADDR_W:0]   ptr;

    logic              in_range;
    logic              conflict;
    logic              range_hit;
    logic              do_write;
    logic              do_read;

    logic [ADDR_W-1:0] arr_addr;
    logic              arr_wr;
    logic [WORD_W-1:0] arr_wdata;
    logic [WORD_W-1:0] arr_rdata;

    // FSM state register; reset always restarts the clear sweep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLEAR;
        end else begin
            state <= next_state;
        end
    end

    // Next state: leave CLEAR after the edge that writes the last word.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            CLEAR:   if (ptr == LAST_PTR) next_state = READY;
            READY:   next_state = READY;
            default: next_state = CLEAR;
        endcase
    end

    // FSM outputs: sweep writes while clearing, commands accepted once ready.
    always_comb begin
        ready = 1'b0;
        sweep = 1'b0;
        case (state)
            CLEAR:   sweep = 1'b1;
            READY:   ready = 1'b1;
            default: sweep = 1'b1;
        endcase
    end

    // Clear pointer walks the array once per sweep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (sweep) begin
            ptr <= ptr + 1'b1;
        end
    end

    // Command decode; everything is gated by ready so the sweep ignores commands.
    assign in_range  = {1'b0, addr} < DEPTH_L;
    assign conflict  = ready & read_en & write_en;
    assign range_hit = ready & (read_en | write_en) & ~in_range;
    assign do_write  = ready & write_en & ~read_en & in_range;
    assign do_read   = ready & read_en & ~write_en;

    assign arr_addr  = sweep ? ptr[ADDR_W-1:0] : addr;
    assign arr_wr    = sweep | do_write;

`ifdef MEM_PARITY_EN
    assign arr_wdata = sweep ? '0 : {even_parity(PARITY_MAX_W'(write_in)), write_in};
    assign read_out  = arr_rdata[DATA_W-1:0];
    assign rd_perr   = rd_valid &
                       (arr_rdata[DATA_W] ^ even_parity(PARITY_MAX_W'(arr_rdata[DATA_W-1:0])));
`else
    assign arr_wdata = sweep ? '0 : write_in;
    assign read_out  = arr_rdata;
    assign rd_perr   = 1'b0;
`endif

    mem_array_sp #(
        .WIDTH  (WORD_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .addr    (arr_addr),
        .wr      (arr_wr),
        .wdata   (arr_wdata),
        .rd      (do_read),
        .rd_zero (~in_range),
        .rdata   (arr_rdata)
    );

    // Read-valid strobe: one cycle per accepted read, aligned with read_out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= do_read;
        end
    end

    // Sticky error flags; a new error in the err_clr cycle wins over the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_conflict <= 1'b0;
            err_range    <= 1'b0;
        end else begin
            if (conflict) begin
                err_conflict <= 1'b1;
            end else if (err_clr) begin
                err_conflict <= 1'b0;
            end
            if (range_hit) begin
                err_range <= 1'b1;
            end else if (err_clr) begin
                err_range <= 1'b0;
            end
        end
    end

endmodule
